ecc_fifo_param: RTL and testbench
=================================

Name: ecc_fifo_param

Overview:
- Parametrised successor to the 32-bit/16-deep SECDED FIFO: synchronous FIFO storing each word as an extended-Hamming (SECDED) codeword.
- Generalised in data width and depth.
- Adds in-band error-injection masks, so benches no longer need hierarchical memory pokes.
- Adds saturating SEC/DED counters, first-error address capture, occupancy, almost-full/empty, and sticky overflow/underflow flags.
- Sits between producer and consumer datapaths wherever buffered data needs soft-error protection.

Parameters:
DATA_W, 32, data width; legal 4..64.
ADDR_W, 4, depth = 2**ADDR_W entries.
CNT_W, 8, width of the SEC and DED error counters.
AF_LVL, 14, almost_full asserts when count >= AF_LVL.
AE_LVL, 2, almost_empty asserts when count <= AE_LVL.
Derived (localparam) P, the smallest P with 2**P >= DATA_W+P+1 (P=6 at DATA_W=32); CW_W = DATA_W+P+1 (39 at 32).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  write request
din  in  DATA_W  write data
inj_mask  in  CW_W  XOR mask applied to the encoded codeword on an accepted write; 0 = no injection
full  out  1  FIFO full
almost_full  out  1  count >= AF_LVL
rd_en  in  1  read request
dout  out  DATA_W  corrected read data
dout_valid  out  1  dout valid this cycle
empty  out  1  FIFO empty
almost_empty  out  1  count <= AE_LVL
count  out  ADDR_W+1  occupancy, 0..2**ADDR_W
sec_err  out  1  single-bit error corrected on the current dout (qualified by dout_valid)
ded_err  out  1  double-bit error detected on the current dout; dout is uncorrected
sec_cnt  out  CNT_W  saturating SEC count
ded_cnt  out  CNT_W  saturating DED count
err_addr  out  ADDR_W  address of the first error since last clear
err_addr_vld  out  1  err_addr holds a capture
clr_err  in  1  clears counters, err_addr_vld, overflow, underflow
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1 at posedge): pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0. dout=0, dout_valid=0, sec_err=0, ded_err=0. Counters=0, err_addr=0, err_addr_vld=0, overflow=0, underflow=0. Memory contents are not cleared. Reset mid-operation discards all data and any read in flight; dout_valid=0 the cycle after reset.
- Codeword layout: [P:0] check bits; bit 0 = overall parity over all other bits; Hamming check bits at [P:1]. [CW_W-1:P+1] = data, so data bit 0 = codeword bit P+1 (bit 7 at DATA_W=32).
- Write accepted iff wr_en && !full. Stored value is enc(din)^inj_mask at wr_ptr; wr_ptr increments modulo 2**ADDR_W.
- Write while full: ignored, overflow set.
- Read accepted iff rd_en && !empty. Memory read and decode are registered: dout, dout_valid=1, sec_err and ded_err appear the cycle after acceptance (latency 1). dout_valid is low otherwise; dout holds its last value.
- Read while empty: ignored, underflow set, dout_valid=0.
- Decode: syndrome s = Hamming syndrome; g = overall parity.
  - s=0, g=0: clean.
  - g=1: SEC. Flip the indicated bit; s=0 means the overall parity bit itself, data unchanged.
  - s!=0, g=0: DED. dout = raw stored data bits.
  - SEC and DED are mutually exclusive.
- Simultaneous accepted read and write: count unchanged. Both are legal when full (read frees a slot the same edge; write accepted only if !full at that edge, i.e. a full FIFO rejects the write). When empty, the read is rejected and the write is accepted. No read-through of same-cycle write data.
- count/full/empty/almost flags are registered and update on the same edge as the pointers.
- Counters increment on each sec_err/ded_err pulse and saturate at 2**CNT_W-1.
- First SEC or DED while err_addr_vld=0 captures the read address and sets err_addr_vld; later errors do not overwrite.
- clr_err: clears on the next edge. If an error occurs in the same cycle, the clear wins and the error is not counted or captured.
- Pointer wrap: ADDR_W+1-bit pointers; full = MSBs differ and low bits equal.

Test Plan:
- Reset, then write 1000,2000,3000,4000,5000 and read all five -> dout in order, each 1 cycle after rd_en, sec_err=ded_err=0, count returns to 0, empty=1.
- Write 2000 with inj_mask=1<<7, read it -> dout=2000, sec_err=1, sec_cnt=1, err_addr=captured address, err_addr_vld=1.
- Write 4000 with inj_mask=(1<<7)|(1<<8), read it -> ded_err=1, sec_err=0, dout=4003 (raw), ded_cnt=1, err_addr unchanged if already valid.
- Fill 16 words -> full=1, almost_full asserted at count 14. A 17th write is dropped, overflow=1. A read of empty after draining sets underflow. clr_err clears both flags.
- Write and read every cycle for 40 cycles from count=3 -> count stays 3, pointers wrap past 15 with data intact, order preserved.
- Assert rst while count=5 with a read in flight -> next cycle dout_valid=0, empty=1, count=0. Inject 300 SEC errors with CNT_W=8 -> sec_cnt=255.

Source files
------------

// File: rtl/ecc_fifo_param.sv
// Synchronous FIFO that stores each word as an extended-Hamming (SECDED) codeword, with in-band
// error injection, saturating SEC/DED counters, first-error address capture and sticky flags.
module ecc_fifo_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8,
   parameter int AF_LVL = 14,
   parameter int AE_LVL = 2,
   localparam int P     = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 : 7,
   localparam int CW_W  = DATA_W + P + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic [CW_W-1:0]   inj_mask,
   output logic              full,
   output logic              almost_full,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              sec_err,
   output logic              ded_err,
   output logic [CNT_W-1:0]  sec_cnt,
   output logic [CNT_W-1:0]  ded_cnt,
   output logic [ADDR_W-1:0] err_addr,
   output logic              err_addr_vld,
   input  logic              clr_err,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] AF_V = (ADDR_W+1)'(AF_LVL);
   localparam logic [ADDR_W:0] AE_V = (ADDR_W+1)'(AE_LVL);

   // H-matrix column of codeword bit k: check bits own the powers of two, data bits take the
   // remaining non-zero values in ascending order, so every column is distinct and non-zero.
   function automatic logic [P-1:0] col_of(input int k);
      logic [P-1:0] r;
      int n;
      r = '0;
      n = 0;
      if (k >= 1 && k <= P) begin
         r[k-1] = 1'b1;
      end else if (k > P) begin
         for (int v = 3; v < 2**P; v++) begin
            if ((v & (v - 1)) != 0) begin
               if (n == k - P - 1) r = v[P-1:0];
               n++;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [P-1:0] syndrome(input logic [CW_W-1:0] c);
      logic [P-1:0] s;
      s = '0;
      for (int k = 1; k < CW_W; k++) begin
         if (c[k]) s = s ^ col_of(k);
      end
      return s;
   endfunction

   function automatic logic [CW_W-1:0] enc(input logic [DATA_W-1:0] d);
      logic [CW_W-1:0] c;
      c = '0;
      c[CW_W-1:P+1] = d;
      c[P:1] = syndrome(c);
      c[0] = ^c[CW_W-1:1];
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   logic [CW_W-1:0]   mem_q [DEPTH];
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
   logic              full_q, full_d, empty_q, empty_d, af_q, ae_q;
   logic              wr_acc, rd_acc;
   logic [CW_W-1:0]   rd_cw, corr_cw;
   logic [P-1:0]      syn;
   logic              par, dec_sec, dec_ded;
   logic [DATA_W-1:0] dout_q;
   logic              dv_q, sec_q, ded_q;
   logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic              err_vld_q, err_vld_d, ovf_q, ovf_d, unf_q, unf_d;

   always_comb begin
      wr_acc   = wr_en && !full_q;
      rd_acc   = rd_en && !empty_q;
      wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, wr_acc};
      rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, rd_acc};
      count_d  = wr_ptr_d - rd_ptr_d;
      full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                 (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
      empty_d  = (wr_ptr_d == rd_ptr_d);
   end

   // A single flip always sets overall parity; syndrome 0 with parity set is the parity bit itself.
   always_comb begin
      rd_cw   = mem_q[rd_ptr_q[ADDR_W-1:0]];
      syn     = syndrome(rd_cw);
      par     = ^rd_cw;
      corr_cw = rd_cw;
      for (int k = 1; k < CW_W; k++) begin
         if (par && (syn == col_of(k))) corr_cw[k] = ~corr_cw[k];
      end
      dec_sec = par;
      dec_ded = !par && (syn != '0);
   end

   always_comb begin
      sec_cnt_d  = sec_cnt_q;
      ded_cnt_d  = ded_cnt_q;
      err_addr_d = err_addr_q;
      err_vld_d  = err_vld_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      if (clr_err) begin
         sec_cnt_d = '0;
         ded_cnt_d = '0;
         err_vld_d = 1'b0;
         ovf_d     = 1'b0;
         unf_d     = 1'b0;
      end else begin
         if (rd_acc && dec_sec) sec_cnt_d = sat_inc(sec_cnt_q);
         if (rd_acc && dec_ded) ded_cnt_d = sat_inc(ded_cnt_q);
         if (rd_acc && (dec_sec || dec_ded) && !err_vld_q) begin
            err_vld_d  = 1'b1;
            err_addr_d = rd_ptr_q[ADDR_W-1:0];
         end
         if (wr_en && full_q)  ovf_d = 1'b1;
         if (rd_en && empty_q) unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc && !rst) mem_q[wr_ptr_q[ADDR_W-1:0]] <= enc(din) ^ inj_mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         af_q       <= 1'b0;
         ae_q       <= 1'b1;
         dout_q     <= '0;
         dv_q       <= 1'b0;
         sec_q      <= 1'b0;
         ded_q      <= 1'b0;
         sec_cnt_q  <= '0;
         ded_cnt_q  <= '0;
         err_addr_q <= '0;
         err_vld_q  <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         af_q       <= (count_d >= AF_V);
         ae_q       <= (count_d <= AE_V);
         dv_q       <= rd_acc;
         sec_q      <= rd_acc && dec_sec;
         ded_q      <= rd_acc && dec_ded;
         if (rd_acc) dout_q <= corr_cw[CW_W-1:P+1];
         sec_cnt_q  <= sec_cnt_d;
         ded_cnt_q  <= ded_cnt_d;
         err_addr_q <= err_addr_d;
         err_vld_q  <= err_vld_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign full         = full_q;
   assign almost_full  = af_q;
   assign empty        = empty_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign dout         = dout_q;
   assign dout_valid   = dv_q;
   assign sec_err      = sec_q;
   assign ded_err      = ded_q;
   assign sec_cnt      = sec_cnt_q;
   assign ded_cnt      = ded_cnt_q;
   assign err_addr     = err_addr_q;
   assign err_addr_vld = err_vld_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_ecc_fifo_param.sv
// Bench for ecc_fifo_param: directed and random traffic checked cycle by cycle against a
// queue-based model that derives expected decode results from the number of injected bit flips.
`timescale 1ns/1ps
module tb_ecc_fifo_param;

   localparam int CW = 39;
   localparam int DEPTH = 16;

   logic           clk = 1'b0;
   logic           rst, wr_en, rd_en, clr_err;
   logic [31:0]    din;
   logic [CW-1:0]  inj_mask;
   logic           full, almost_full, empty, almost_empty, dout_valid, sec_err, ded_err;
   logic           err_addr_vld, overflow, underflow;
   logic [31:0]    dout;
   logic [4:0]     count;
   logic [7:0]     sec_cnt, ded_cnt;
   logic [3:0]     err_addr;

   ecc_fifo_param dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .inj_mask(inj_mask),
      .full(full), .almost_full(almost_full), .rd_en(rd_en), .dout(dout),
      .dout_valid(dout_valid), .empty(empty), .almost_empty(almost_empty), .count(count),
      .sec_err(sec_err), .ded_err(ded_err), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt),
      .err_addr(err_addr), .err_addr_vld(err_addr_vld), .clr_err(clr_err),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]   d;
      logic [CW-1:0] m;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_dout;
   int          m_sc, m_dc, m_ea, m_ra;
   bit          m_ev, m_ovf, m_unf;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] rmask(input int nbits);
      logic [CW-1:0] m;
      int a, b;
      m = '0;
      a = $urandom_range(0, CW-1);
      if (nbits >= 1) m[a] = 1'b1;
      if (nbits == 2) begin
         b = $urandom_range(0, CW-1);
         while (b == a) b = $urandom_range(0, CW-1);
         m[b] = 1'b1;
      end
      return m;
   endfunction

   task automatic check_all(input bit racc, input bit esec, input bit eded);
      int n;
      n = q.size();
      chk("dout_valid", 64'(dout_valid), 64'(racc));
      chk("dout", 64'(dout), 64'(m_dout));
      if (racc) begin
         chk("sec_err", 64'(sec_err), 64'(esec));
         chk("ded_err", 64'(ded_err), 64'(eded));
      end
      chk("count", 64'(count), 64'(n));
      chk("full", 64'(full), 64'(n == DEPTH));
      chk("empty", 64'(empty), 64'(n == 0));
      chk("almost_full", 64'(almost_full), 64'(n >= 14));
      chk("almost_empty", 64'(almost_empty), 64'(n <= 2));
      chk("sec_cnt", 64'(sec_cnt), 64'(m_sc));
      chk("ded_cnt", 64'(ded_cnt), 64'(m_dc));
      chk("err_addr_vld", 64'(err_addr_vld), 64'(m_ev));
      chk("err_addr", 64'(err_addr), 64'(m_ea));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("underflow", 64'(underflow), 64'(m_unf));
   endtask

   task automatic cycle(input bit wr, input logic [31:0] d, input logic [CW-1:0] m,
                        input bit rd, input bit clr);
      int   occ, nb;
      bit   wacc, racc, esec, eded;
      ent_t e;
      wr_en = wr; din = d; inj_mask = m; rd_en = rd; clr_err = clr;
      occ  = q.size();
      wacc = wr && (occ < DEPTH);
      racc = rd && (occ > 0);
      @(posedge clk); #1;
      esec = 1'b0; eded = 1'b0;
      if (racc) begin
         e = q.pop_front();
         nb = $countones(e.m);
         esec = (nb == 1);
         eded = (nb == 2);
         m_dout = eded ? (e.d ^ e.m[CW-1:7]) : e.d;
      end
      if (wacc) q.push_back('{d, m});
      if (clr) begin
         m_sc = 0; m_dc = 0; m_ev = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         if (esec && m_sc < 255) m_sc++;
         if (eded && m_dc < 255) m_dc++;
         if ((esec || eded) && !m_ev) begin
            m_ev = 1'b1;
            m_ea = m_ra;
         end
         if (wr && occ == DEPTH) m_ovf = 1'b1;
         if (rd && occ == 0) m_unf = 1'b1;
      end
      if (racc) m_ra = (m_ra + 1) % DEPTH;
      wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; inj_mask = '0;
      check_all(racc, esec, eded);
   endtask

   task automatic do_reset(input bit rd);
      rst = 1'b1; rd_en = rd; wr_en = 1'b0; clr_err = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; rd_en = 1'b0;
      q.delete();
      m_dout = '0; m_sc = 0; m_dc = 0; m_ea = 0; m_ra = 0;
      m_ev = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      check_all(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [CW-1:0] b7, b78;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0; inj_mask = '0;
      b7  = '0; b7[7] = 1'b1;
      b78 = b7; b78[8] = 1'b1;
      repeat (2) @(posedge clk);
      do_reset(1'b0);

      for (int k = 1; k <= 5; k++) cycle(1'b1, 32'(k * 1000), '0, 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         cycle(1'b0, '0, '0, 1'b1, 1'b0);
         chk("inorder_dout", 64'(dout), 64'(k * 1000));
      end
      chk("drained_empty", 64'(empty), 64'd1);

      cycle(1'b1, 32'd2000, b7, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      chk("sec_dout", 64'(dout), 64'd2000);
      chk("sec_flag", 64'(sec_err), 64'd1);
      chk("sec_addr", 64'(err_addr), 64'd5);

      cycle(1'b1, 32'd4000, b78, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      chk("ded_dout", 64'(dout), 64'd4003);
      chk("ded_cnt1", 64'(ded_cnt), 64'd1);
      chk("ded_addr_kept", 64'(err_addr), 64'd5);

      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 16; k++) cycle(1'b1, $urandom, rmask($urandom_range(0, 2)), 1'b0, 1'b0);
      chk("fill_full", 64'(full), 64'd1);
      cycle(1'b1, 32'hDEAD_BEEF, '0, 1'b0, 1'b0);
      chk("ovf_set", 64'(overflow), 64'd1);
      cycle(1'b1, 32'h1234_5678, '0, 1'b1, 1'b0);
      for (int k = 0; k < 16; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
      chk("unf_set", 64'(underflow), 64'd1);
      cycle(1'b1, 32'h0BAD_CAFE, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      chk("clr_ovf", 64'(overflow), 64'd0);

      for (int k = 0; k < 2; k++) cycle(1'b1, $urandom, '0, 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) cycle(1'b1, $urandom, rmask($urandom_range(0, 2)), 1'b1, 1'b0);
      chk("steady_count", 64'(count), 64'd3);

      cycle(1'b1, $urandom, '0, 1'b0, 1'b0);
      cycle(1'b1, $urandom, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      do_reset(1'b1);
      chk("rst_dv", 64'(dout_valid), 64'd0);

      cycle(1'b1, 32'hA5A5_0001, rmask(1), 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b1);
      chk("clr_wins", 64'(sec_cnt), 64'd0);

      for (int k = 0; k < 300; k++) cycle(1'b1, $urandom, rmask(1), k > 0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      chk("sec_sat", 64'(sec_cnt), 64'd255);

      for (int k = 0; k < 300; k++)
         cycle($urandom_range(0, 1) == 1, $urandom, rmask($urandom_range(0, 2)),
               $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
